pool_packer: RTL and testbench
==============================

Name: pool_packer

Overview:
- Downstream stage of the max-pooling unit. Consumes one pooled result per valid strobe, which is either one 14-bit lane or two packed 7-bit lanes.
- Applies optional per-lane ReLU.
- Packs PACK_NUM results into one wide word and buffers the words in a small FIFO.
- Hands words to the output-buffer writer over a valid/ready handshake.

Parameters:
- SA_OUTPUT_WIDTH, 14: width of one pooled result (two 7-bit sub-lanes in 2*2 mode).
- PACK_NUM, 4: results per output word.
- FIFO_DEPTH, 4: output word FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- pool_enable  input  1  pooling window active; falling edge triggers auto-flush.
- out_model  input  1  1 = 4*4 mode (one 14-bit lane), 0 = 2*2 mode (two 7-bit lanes [13:7],[6:0]).
- Sx  input  1  1 = signed data, 0 = unsigned.
- relu_en  input  1  enable ReLU clamp (only meaningful when Sx=1).
- in_valid  input  1  pooled result present this cycle.
- in_data  input  SA_OUTPUT_WIDTH  pooled result.
- flush  input  1  force emission of a partial word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  SA_OUTPUT_WIDTH*PACK_NUM  packed word; lane 0 at LSBs.
- out_count  output  $clog2(PACK_NUM)+1  number of valid lanes in out_data (1..PACK_NUM).
- overflow  output  1  sticky: a word was dropped on FIFO full.
- busy  output  1  partial word held or FIFO non-empty.

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, lane index 0, partial word 0, overflow=0. All outputs 0.
- Mode capture:
  - out_model and Sx are latched on the pool_enable rising edge (IDLE->ACTIVE).
  - Changes to them while ACTIVE are ignored.
- relu_en is sampled per accepted input.
- ReLU:
  - Applies only if relu_en && latched Sx.
  - 4*4 mode: if in_data[13]=1, lane := 0.
  - 2*2 mode: each 7-bit sub-lane is clamped independently on its own MSB.
  - Unsigned data passes unchanged.
- States:
  - IDLE: inputs ignored. pool_enable=1 -> ACTIVE.
  - ACTIVE: in_valid=1 writes the processed value into lane[idx], then idx++.
    - When idx reaches PACK_NUM-1 and a value is accepted, the word is complete. Push it with count=PACK_NUM and reset idx to 0.
    - flush=1 with idx>0 (counting any same-cycle accepted input) pushes a partial word with count=idx. Unused lanes are 0.
    - flush with nothing held is a no-op.
    - pool_enable=0 -> DRAIN.
  - DRAIN: the held partial word (if any) is pushed in the first DRAIN cycle. Then -> IDLE. in_valid is ignored in DRAIN.
  - pool_enable=1 during DRAIN is registered only after returning to IDLE, one cycle later.
- Push latency: a word pushed on cycle N appears as out_valid=1 on cycle N+1 (registered FIFO head).
- Handshake:
  - Head pops on out_valid && out_ready.
  - out_data and out_count are stable while out_valid && !out_ready.
- FIFO boundary cases:
  - Push while full is allowed only if a pop occurs the same cycle.
  - Otherwise the word is dropped, overflow is set to 1 (sticky until reset), and packing continues at idx=0.
  - Pop on empty has no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Simultaneous in_valid + flush: the input is included first, then the word is emitted.
- busy = (idx!=0) || FIFO non-empty || state==DRAIN.
- Reset mid-operation: all state, partial word and FIFO contents are discarded immediately.

Decomposition:
- Shared package pool_pkg holds:
  - typedef pool_state_e {IDLE, ACTIVE, DRAIN};
  - SA_OUTPUT_WIDTH;
  - HALF_WIDTH=7;
  - a relu_lane function used by this block and any future requantizer.
- One sub-module, pool_word_fifo (parameterised width/depth, async active-low reset, registered head, full/empty flags). It is reused by other writeback paths.

Test Plan:
- Basic 4*4 pack: Sx=1, relu_en=0. Inputs 0x0001, 0x0002, 0x3FFF, 0x2000 with out_ready=1 -> one cycle after the 4th input, out_data=0x2000_3FFF_0002_0001 (14-bit lanes) and out_count=4.
- ReLU 2*2 pack: out_model=0, Sx=1, relu_en=1. Input 0x2041 (upper=0x40 negative, lower=0x41 negative) -> lane0=0x0000. Input 0x0FBF (upper=0x1F, lower=0x3F) -> lane1 unchanged. With Sx=0 the same inputs pass unmodified.
- Auto-flush: 3 inputs, then pool_enable drops -> exactly one word with count=3, lane3=0. busy falls after the pop. A following pool_enable rise returns to ACTIVE.
- Backpressure/overflow: out_ready=0, push 5 full words -> 4 held, overflow=1 after the 5th. Then out_ready=1 -> words 1-4 emerge in order, with out_data held stable while stalled.
- Full push with simultaneous pop: FIFO full and out_ready=1 on the completing cycle -> no drop, overflow stays 0.
- Reset mid-word: reset low after 2 inputs and a non-empty FIFO -> out_valid=0, busy=0 and overflow=0 immediately. Subsequent pack starts at lane 0.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling writeback path.
package pool_pkg;

  localparam int unsigned SA_OUTPUT_WIDTH = 14;
  localparam int unsigned HALF_WIDTH      = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } pool_state_e;

  // Clamp negative values to zero; in split mode each half clamps on its own MSB.
  function automatic logic [SA_OUTPUT_WIDTH-1:0] relu_lane(
    input logic [SA_OUTPUT_WIDTH-1:0] data,
    input logic                       full_lane,
    input logic                       enable
  );
    logic [SA_OUTPUT_WIDTH-1:0] result;
    result = data;
    if (enable) begin
      if (full_lane) begin
        if (data[SA_OUTPUT_WIDTH-1]) result = '0;
      end else begin
        if (data[SA_OUTPUT_WIDTH-1]) result[SA_OUTPUT_WIDTH-1:HALF_WIDTH] = '0;
        if (data[HALF_WIDTH-1])      result[HALF_WIDTH-1:0] = '0;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pool_word_fifo.sv
// Word FIFO with registered head, wrap-bit full/empty and push-through-pop when full.
module pool_word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pool_packer.sv
// Packs pooled results (with optional ReLU) into wide words and queues them for the output writer.
module pool_packer #(
  parameter int unsigned SA_OUTPUT_WIDTH = pool_pkg::SA_OUTPUT_WIDTH,
  parameter int unsigned PACK_NUM        = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pool_enable,
  input  logic                                out_model,
  input  logic                                Sx,
  input  logic                                relu_en,
  input  logic                                in_valid,
  input  logic [SA_OUTPUT_WIDTH-1:0]          in_data,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SA_OUTPUT_WIDTH*PACK_NUM-1:0] out_data,
  output logic [$clog2(PACK_NUM):0]           out_count,
  output logic                                overflow,
  output logic                                busy
);

  import pool_pkg::*;

  localparam int unsigned IDXW = $clog2(PACK_NUM);
  localparam int unsigned CW   = IDXW + 1;
  localparam int unsigned DW   = SA_OUTPUT_WIDTH * PACK_NUM;

  pool_state_e state;
  pool_state_e state_nx;

  logic [PACK_NUM-1:0][SA_OUTPUT_WIDTH-1:0] lanes;
  logic [PACK_NUM-1:0][SA_OUTPUT_WIDTH-1:0] next_lanes;
  logic [SA_OUTPUT_WIDTH-1:0]               lane_val;
  logic [IDXW-1:0]                          idx;
  logic [CW-1:0]                            held;
  logic                                     model_q;
  logic                                     sx_q;
  logic                                     push;
  logic                                     clear;
  logic                                     fifo_full;
  logic                                     fifo_empty;
  logic [CW+DW-1:0]                         head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pool_enable) state_nx = ACTIVE;
      ACTIVE:  if (!pool_enable) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Same-cycle input lands in its lane before the completion/flush decision.
  always_comb begin
    lane_val   = relu_lane(in_data, model_q, relu_en && sx_q);
    next_lanes = lanes;
    held       = {1'b0, idx};
    push       = 1'b0;
    clear      = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (in_valid) begin
          next_lanes[idx] = lane_val;
          held            = held + CW'(1);
        end
        if ((held == CW'(PACK_NUM)) || (flush && (held != '0))) begin
          push  = 1'b1;
          clear = 1'b1;
        end
      end
      DRAIN: begin
        if (idx != '0) begin
          push  = 1'b1;
          clear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      lanes    <= '0;
      model_q  <= 1'b0;
      sx_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if ((state == IDLE) && pool_enable) begin
        model_q <= out_model;
        sx_q    <= Sx;
      end
      if (clear) begin
        idx   <= '0;
        lanes <= '0;
      end else begin
        idx   <= held[IDXW-1:0];
        lanes <= next_lanes;
      end
      if (push && fifo_full && !out_ready) overflow <= 1'b1;
    end
  end

  pool_word_fifo #(
    .WIDTH(CW + DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_data({held, next_lanes}),
    .pop      (out_ready),
    .head_data(head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head[DW-1:0];
  assign out_count = head[CW+DW-1:DW];
  assign busy      = (idx != '0) || !fifo_empty || (state == DRAIN);

endmodule

// File: tb/tb_pool_packer.sv
// Self-checking bench for pool_packer against a queue-based behavioural model.
module tb_pool_packer;

  localparam int W  = 14;
  localparam int P  = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           pool_enable = 1'b0;
  logic           out_model = 1'b1;
  logic           Sx = 1'b0;
  logic           relu_en = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [W*P-1:0] out_data;
  logic [CW-1:0]  out_count;
  logic           overflow;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 active, 2 drain
  int             m_state = 0;
  bit             m_model, m_sx, m_ovf;
  int             held[$];
  logic [W*P-1:0] q_data[$];
  int             q_cnt[$];

  pool_packer #(.SA_OUTPUT_WIDTH(W), .PACK_NUM(P), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .pool_enable(pool_enable), .out_model(out_model),
    .Sx(Sx), .relu_en(relu_en), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int relu_model(int d, bit en);
    int hi, lo;
    if (!(en && m_sx)) return d;
    if (m_model) return (d >= 8192) ? 0 : d;
    hi = d / 128;
    lo = d % 128;
    if (hi >= 64) hi = 0;
    if (lo >= 64) lo = 0;
    return hi * 128 + lo;
  endfunction

  task automatic model_clear();
    m_state = 0; m_ovf = 1'b0;
    held.delete(); q_data.delete(); q_cnt.delete();
  endtask

  task automatic cycle();
    bit do_pop, do_push, room;
    logic [W*P-1:0] w;
    int cnt;
    do_pop = out_ready && (q_data.size() != 0);
    do_push = 1'b0; w = '0; cnt = 0;
    case (m_state)
      0: if (pool_enable) begin m_state = 1; m_model = out_model; m_sx = Sx; end
      1: begin
        if (in_valid) held.push_back(relu_model(int'(in_data), relu_en));
        if (held.size() == P || (flush && held.size() != 0)) do_push = 1'b1;
        if (!pool_enable) m_state = 2;
      end
      default: begin do_push = (held.size() != 0); m_state = 0; end
    endcase
    if (do_push) begin
      foreach (held[k]) w[W*k +: W] = W'(held[k]);
      cnt = held.size();
      held.delete();
    end
    room = (q_data.size() < D) || do_pop;
    if (do_pop) begin void'(q_data.pop_front()); void'(q_cnt.pop_front()); end
    if (do_push) begin
      if (room) begin q_data.push_back(w); q_cnt.push_back(cnt); end
      else m_ovf = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic put(int d);
    in_valid = 1'b1; in_data = W'(d); cycle(); in_valid = 1'b0;
  endtask

  task automatic test_reset();
    pool_enable = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    model_clear();
    #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_tests++; if (out_count !== '0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic_pack();
    pool_enable = 1'b1; out_model = 1'b1; Sx = 1'b1; relu_en = 1'b0; out_ready = 1'b1;
    cycle();
    put('h0001); put('h0002); put('h3FFF); put('h2000);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    n_tests++; if (out_data !== {14'h2000, 14'h3FFF, 14'h0002, 14'h0001}) begin
      n_fail++; $display("FAIL basic_data got %h want %h", out_data, {14'h2000, 14'h3FFF, 14'h0002, 14'h0001}); end
    n_tests++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL basic_count got %0d want 4", out_count); end
    cycle();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got %0b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %0b want 0", busy); end
    pool_enable = 1'b0; cycle();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy got %0b want 1", busy); end
    cycle();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL after_drain_busy got %0b want 0", busy); end
  endtask

  task automatic test_relu_2x2();
    for (int pass = 0; pass < 2; pass++) begin
      logic [W*P-1:0] want;
      pool_enable = 1'b1; out_model = 1'b0; Sx = (pass == 0); relu_en = 1'b1; out_ready = 1'b0;
      cycle();
      out_model = 1'b1; Sx = ~Sx;  // must be ignored while active
      put('h2041);
      flush = 1'b1; put('h0FBF); flush = 1'b0;
      want = (pass == 0) ? {28'h0, 14'h0FBF, 14'h0000} : {28'h0, 14'h0FBF, 14'h2041};
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL relu_valid pass %0d got %0b want 1", pass, out_valid); end
      n_tests++; if (out_data !== want) begin n_fail++; $display("FAIL relu_data pass %0d got %h want %h", pass, out_data, want); end
      n_tests++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL relu_count pass %0d got %0d want 2", pass, out_count); end
      out_ready = 1'b1; pool_enable = 1'b0; cycle(); cycle();
    end
  endtask

  task automatic test_auto_flush();
    logic [W-1:0] v[3];
    pool_enable = 1'b1; out_model = 1'b1; Sx = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin v[i] = W'($urandom); put(int'(v[i])); end
    pool_enable = 1'b0; cycle();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL aflush_early got %0b want 0", out_valid); end
    cycle();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL aflush_valid got %0b want 1", out_valid); end
    n_tests++; if (out_count !== 3'd3) begin n_fail++; $display("FAIL aflush_count got %0d want 3", out_count); end
    n_tests++; if (out_data !== {14'h0, v[2], v[1], v[0]}) begin
      n_fail++; $display("FAIL aflush_data got %h want %h", out_data, {14'h0, v[2], v[1], v[0]}); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL aflush_busy got %0b want 1", busy); end
    out_ready = 1'b1; cycle();
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL aflush_pop busy %0b valid %0b want 0 0", busy, out_valid); end
    pool_enable = 1'b1; cycle();
    put(int'(v[0]));
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reenter_busy got %0b want 1", busy); end
    out_ready = 1'b0; flush = 1'b1; cycle(); flush = 1'b0;
    n_tests++; if (out_count !== 3'd1 || out_data !== {42'h0, v[0]}) begin
      n_fail++; $display("FAIL reenter_word got %0d/%h want 1/%h", out_count, out_data, {42'h0, v[0]}); end
    out_ready = 1'b1; pool_enable = 1'b0; cycle(); cycle();
  endtask

  task automatic test_overflow();
    pool_enable = 1'b1; out_model = 1'b1; Sx = 1'b0; out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) put(int'($urandom_range(0, 16383)));
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got %0b want 0", overflow); end
    for (int i = 0; i < 4; i++) put(int'($urandom_range(0, 16383)));
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after got %0b want 1", overflow); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== q_data[0]) begin
        n_fail++; $display("FAIL ovf_stall %0d got %0b/%h want 1/%h", i, out_valid, out_data, q_data[0]); end
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== q_data[0] || out_count !== CW'(q_cnt[0])) begin
        n_fail++; $display("FAIL ovf_drain %0d got %0b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_count, q_data[0], q_cnt[0]); end
      cycle();
    end
    n_tests++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_empty valid %0b ovf %0b want 0 1", out_valid, overflow); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v[4];
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) put(int'($urandom_range(0, 16383)));
    n_tests++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre busy %0b valid %0b want 1 1", busy, out_valid); end
    reset = 1'b0; #2;
    model_clear();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs valid %0b busy %0b ovf %0b want 0 0 0", out_valid, busy, overflow); end
    @(posedge clk); #1;
    reset = 1'b1; pool_enable = 1'b1; out_model = 1'b1; Sx = 1'b0; out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin v[i] = W'($urandom); put(int'(v[i])); end
    n_tests++; if (out_data !== {v[3], v[2], v[1], v[0]} || out_count !== 3'd4) begin
      n_fail++; $display("FAIL midrst_repack got %h/%0d want %h/4", out_data, out_count, {v[3], v[2], v[1], v[0]}); end
    cycle();
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 19; i++) put(int'($urandom_range(0, 16383)));
    out_ready = 1'b1;
    put(int'($urandom_range(0, 16383)));
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %0b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== q_data[0] || out_count !== CW'(q_cnt[0])) begin
        n_fail++; $display("FAIL fullpop_word %0d got %0b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_count, q_data[0], q_cnt[0]); end
      cycle();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit exp_busy;
    for (int i = 0; i < 1500; i++) begin
      if (pool_enable) begin
        if ($urandom_range(0, 63) == 0) pool_enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) pool_enable = 1'b1;
      out_model = 1'($urandom_range(0, 1));
      Sx        = 1'($urandom_range(0, 1));
      relu_en   = 1'($urandom_range(0, 1));
      in_valid  = pool_enable && ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ((i % 400) < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle();
      exp_busy = (held.size() != 0) || (q_data.size() != 0) || (m_state == 2);
      n_tests++; if (out_valid !== (q_data.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", i, out_valid, q_data.size() != 0); end
      if (q_data.size() != 0) begin
        n_tests++; if (out_data !== q_data[0] || out_count !== CW'(q_cnt[0])) begin
          n_fail++; $display("FAIL rand_word cyc %0d got %h/%0d want %h/%0d", i, out_data, out_count, q_data[0], q_cnt[0]); end
      end
      n_tests++; if (busy !== exp_busy || overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_flags cyc %0d busy %0b ovf %0b want %0b %0b", i, busy, overflow, exp_busy, m_ovf); end
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_pack();
    test_relu_2x2();
    test_auto_flush();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
